cfu_precision_mac: RTL
======================

// Module: cfu_precision_mac
// PURPOSE
//  Next-generation CFU MAC: SIMD dot-product with runtime precision (8/4/2-bit lanes), NUM_ACC independent accumulators.
//  Sits on the CPU custom-function-unit port (cmd/rsp valid-ready).
//  Two-stage datapath, products registered then accumulated, and a 3-state FSM.
//  Supports per-layer input offset, accumulator clear/preload/readback.
// PARAMETERS
//  NUM_ACC    4    number of accumulators; index = cmd_payload_function_id[9:3]
//  ACC_W      32   accumulator width; rsp carries acc sign-extended/truncated to 32 bits
//  IN_OFFSET  128  reset value of the 9-bit signed input offset used in 8-bit mode
// PORTS
//  clk                      in   1   clock
//  reset                    in   1   reset, synchronous, active-high
//  cmd_valid                in   1   command valid
//  cmd_ready                out  1   command accept; high only in IDLE
//  cmd_payload_function_id  in   10  [2:0] opcode, [9:3] accumulator index
//  cmd_payload_inputs_0     in   32  activations / operand A
//  cmd_payload_inputs_1     in   32  weights / operand B
//  rsp_valid                out  1   response valid
//  rsp_ready                in   1   response accept
//  rsp_payload_outputs_0    out  32  result
// BEHAVIOUR
//  Reset: rsp_valid=0, rsp_payload_outputs_0=0, all accs=0, mode=8-bit, offset=IN_OFFSET, FSM=IDLE.
//  FSM: IDLE --(cmd_valid)--> EXEC --> RESP --(rsp_ready)--> IDLE.
//  Accept in cycle t: rsp_valid high from t+2 and held with payload stable until rsp_ready sampled high.
//  rsp_ready high in the first RESP cycle completes the transfer that cycle; next accept no earlier than t+3.
//  cmd_ready = (state==IDLE); one command in flight.
//  Opcodes (all respond once):
//   0 MAC   : acc[i] += dot(A,B); rsp = new acc[i]
//   1 CLEAR : acc[i] = 0; rsp = old acc[i]
//   2 READ  : rsp = acc[i]
//   3 MODE  : inputs_0[1:0] 0=8b,1=4b,2=2b; code 3 ignored; rsp = previous mode
//   4 OFFSET: offset = inputs_0[8:0]; rsp = previous offset sign-extended
//   5 WRITE : acc[i] = inputs_0 sign-extended to ACC_W; rsp = inputs_0
//   6,7     : no state change; rsp = 0
//  Lanes, lane k at bits [k*w +: w]:
//   8b: 4 lanes; a = signed A byte + offset (10-bit signed); b = signed B byte.
//   4b: 8 lanes; a = unsigned A nibble, no offset; b = signed B nibble.
//   2b: 16 lanes; a = unsigned A 2-bit, no offset; b = signed B 2-bit.
//  Dot product: exact signed sum of all lane products, sign-extended to ACC_W before accumulation.
//  Mode is sampled at accept; a MODE command takes effect for the next command.
//  Accumulation wraps modulo 2^ACC_W (unless saturation is enabled).
//  Index i >= NUM_ACC: MAC/CLEAR/WRITE have no effect; rsp = 0; READ returns 0.
//  reset during EXEC or RESP: in-flight command dropped, no response issued, all state returns to reset values.
//  cmd_valid while busy: ignored (not accepted); master must hold it.
// CONFIGURATION
//  CFU_MAC_SATURATE_EN defined:
//   MAC clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on signed overflow.
//   WRITE, CLEAR and READ are unchanged.
//  CFU_MAC_SATURATE_EN undefined:
//   plain two's-complement wrap.
//   No clamp logic is synthesised.
// TESTING
//  reset; MAC acc0, A=0x81818181, B=0x02020202, 8b, offset 128 -> rsp 0x00000008 at t+2
//  MODE 1; MAC acc1, A=0xFFFFFFFF, B=0x11111111 -> rsp 0x00000078 (8 lanes x 15 x 1)
//  MODE 2; MAC acc2, A=0xFFFFFFFF, B=0xFFFFFFFF -> rsp 0xFFFFFFD0 (16 x 3 x -1)
//  WRITE acc3=0x7FFFFFF0; MODE 1; MAC A=0xFFFFFFFF, B=0x11111111 -> 0x80000068 (wrap) / 0x7FFFFFFF (CFU_MAC_SATURATE_EN)
//  Hold rsp_ready=0 for 5 cycles -> rsp_valid and payload stable, cmd_ready=0; release -> IDLE next cycle
//  Assert reset in EXEC of a MAC -> no rsp_valid pulse; READ acc0 after -> 0x00000000; index 9 READ -> 0

Source files
------------

// File: rtl/cfu_precision_mac.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_precision_mac
//  Description : CFU-port SIMD dot-product MAC with runtime lane precision
//                (8/4/2-bit), NUM_ACC accumulators, input offset, and
//                clear/preload/readback. Products are registered at accept,
//                summed and accumulated in EXEC, returned in RESP.
//  Config      : define CFU_MAC_SATURATE_EN to clamp MAC results on signed
//                overflow instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfu_precision_mac #(
    parameter int NUM_ACC   = 4,
    parameter int ACC_W     = 32,   // must exceed the 22-bit dot-product width
    parameter int IN_OFFSET = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int c_LANES  = 16;   // widest lane count (2-bit mode)
    localparam int c_PROD_W = 18;   // holds (-384..382) x (-128..127)
    localparam int c_DOT_W  = 22;   // 16 products of c_PROD_W without overflow
    localparam int c_IDX_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    localparam logic [2:0] c_OP_MAC    = 3'd0;
    localparam logic [2:0] c_OP_CLEAR  = 3'd1;
    localparam logic [2:0] c_OP_READ   = 3'd2;
    localparam logic [2:0] c_OP_MODE   = 3'd3;
    localparam logic [2:0] c_OP_OFFSET = 3'd4;
    localparam logic [2:0] c_OP_WRITE  = 3'd5;

    localparam logic [1:0] c_MODE_8B = 2'd0;
    localparam logic [1:0] c_MODE_4B = 2'd1;
    localparam logic [1:0] c_MODE_2B = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [8:0]             offset_q, offset_d;
    logic [ACC_W-1:0]       acc_q [NUM_ACC];
    logic [2:0]             op_q;
    logic [6:0]             idx_q;
    logic [31:0]            in0_q;
    logic [c_PROD_W-1:0]    prod_q [c_LANES];
    logic [c_PROD_W-1:0]    prod_d [c_LANES];
    logic [31:0]            rsp_q, rsp_d;

    logic [c_PROD_W-1:0]    w_a [c_LANES];
    logic [c_PROD_W-1:0]    w_b [c_LANES];
    logic                   w_accept;
    logic                   w_idx_ok;
    logic [ACC_W-1:0]       w_acc_sel;
    logic [c_DOT_W-1:0]     w_dot;
    logic [ACC_W-1:0]       w_dot_ext;
    logic [ACC_W-1:0]       w_mac_sum;
    logic [ACC_W-1:0]       w_mac_res;
    logic                   w_acc_we;
    logic [ACC_W-1:0]       w_acc_wdata;

    // Signed acc value to the 32-bit response (sign-extend or truncate).
    function automatic logic [31:0] f_to_rsp(input logic [ACC_W-1:0] v);
        return 32'($signed(v));
    endfunction

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_EXEC;
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_accept              = cmd_valid & cmd_ready;
    assign rsp_payload_outputs_0 = rsp_q;

    // Stage 1: per-lane operands and products from the mode current at accept.
    always_comb begin
        for (int k = 0; k < c_LANES; k++) begin
            w_a[k] = '0;
            w_b[k] = '0;
            case (mode_q)
                c_MODE_8B: if (k < 4) begin
                    w_a[k] = c_PROD_W'($signed(cmd_payload_inputs_0[8*k +: 8]))
                           + c_PROD_W'($signed(offset_q));
                    w_b[k] = c_PROD_W'($signed(cmd_payload_inputs_1[8*k +: 8]));
                end
                c_MODE_4B: if (k < 8) begin
                    w_a[k] = c_PROD_W'(cmd_payload_inputs_0[4*k +: 4]);
                    w_b[k] = c_PROD_W'($signed(cmd_payload_inputs_1[4*k +: 4]));
                end
                c_MODE_2B: begin
                    w_a[k] = c_PROD_W'(cmd_payload_inputs_0[2*k +: 2]);
                    w_b[k] = c_PROD_W'($signed(cmd_payload_inputs_1[2*k +: 2]));
                end
                default: ;
            endcase
            // Low c_PROD_W bits of the product are exact: the true value fits.
            prod_d[k] = w_a[k] * w_b[k];
        end
    end

    // Stage 2: signed sum of registered lane products.
    always_comb begin
        w_dot = '0;
        for (int k = 0; k < c_LANES; k++) begin
            w_dot = w_dot + c_DOT_W'($signed(prod_q[k]));
        end
    end

    assign w_dot_ext = ACC_W'($signed(w_dot));
    assign w_idx_ok  = ({25'd0, idx_q} < NUM_ACC);
    assign w_acc_sel = w_idx_ok ? acc_q[idx_q[c_IDX_W-1:0]] : '0;
    assign w_mac_sum = w_acc_sel + w_dot_ext;

`ifdef CFU_MAC_SATURATE_EN
    logic w_ovf;
    // Overflow only when both addends share a sign the sum does not.
    assign w_ovf     = (w_acc_sel[ACC_W-1] == w_dot_ext[ACC_W-1]) &&
                       (w_mac_sum[ACC_W-1] != w_acc_sel[ACC_W-1]);
    assign w_mac_res = !w_ovf ? w_mac_sum :
                       w_acc_sel[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_mac_res = w_mac_sum;
`endif

    // EXEC-cycle opcode decode: state updates and response value.
    always_comb begin
        mode_d      = mode_q;
        offset_d    = offset_q;
        w_acc_we    = 1'b0;
        w_acc_wdata = w_mac_res;
        rsp_d       = '0;
        case (op_q)
            c_OP_MAC: if (w_idx_ok) begin
                w_acc_we    = 1'b1;
                w_acc_wdata = w_mac_res;
                rsp_d       = f_to_rsp(w_mac_res);
            end
            c_OP_CLEAR: if (w_idx_ok) begin
                w_acc_we    = 1'b1;
                w_acc_wdata = '0;
                rsp_d       = f_to_rsp(w_acc_sel);
            end
            c_OP_READ: rsp_d = f_to_rsp(w_acc_sel);
            c_OP_MODE: begin
                rsp_d = {30'd0, mode_q};
                if (in0_q[1:0] != 2'd3) mode_d = in0_q[1:0];
            end
            c_OP_OFFSET: begin
                rsp_d    = 32'($signed(offset_q));
                offset_d = in0_q[8:0];
            end
            c_OP_WRITE: if (w_idx_ok) begin
                w_acc_we    = 1'b1;
                w_acc_wdata = ACC_W'($signed(in0_q));
                rsp_d       = in0_q;
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Command capture at accept; architectural updates and response in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= c_MODE_8B;
            offset_q <= 9'(IN_OFFSET);
            op_q     <= '0;
            idx_q    <= '0;
            in0_q    <= '0;
            rsp_q    <= '0;
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
            for (int k = 0; k < c_LANES; k++) prod_q[k] <= '0;
        end else begin
            if (w_accept) begin
                op_q   <= cmd_payload_function_id[2:0];
                idx_q  <= cmd_payload_function_id[9:3];
                in0_q  <= cmd_payload_inputs_0;
                prod_q <= prod_d;
            end
            if (state_q == S_EXEC) begin
                rsp_q    <= rsp_d;
                mode_q   <= mode_d;
                offset_q <= offset_d;
                if (w_acc_we) acc_q[idx_q[c_IDX_W-1:0]] <= w_acc_wdata;
            end
        end
    end

endmodule
`default_nettype wire
